// File: rtl/freq_gen_pkg.sv
// Shared constants and FSM encoding for the burst square-wave generator.
package freq_gen_pkg;

    localparam int WIDTH    = 16;
    localparam int HALF_MIN = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } fg_state_t;

endpackage

// File: rtl/frequency_generator_if.sv
// Control/status bundle between a burst requester and frequency_generator.
interface frequency_generator_if
    import freq_gen_pkg::*;
#(
    parameter int WIDTH = freq_gen_pkg::WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] half_period;
    logic [WIDTH-1:0] num_cycles;
    logic             abort;
    logic             wave;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] cycles_sent;

    modport master (
        output start, half_period, num_cycles, abort,
        input  wave, busy, done, cycles_sent
    );

    modport slave (
        input  start, half_period, num_cycles, abort,
        output wave, busy, done, cycles_sent
    );

endinterface

// File: rtl/half_period_timer.sv
// Loadable down-counter that flags expiry when it sits at zero.
module half_period_timer
    import freq_gen_pkg::*;
#(
    parameter int WIDTH = freq_gen_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: count_d is given its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/frequency_generator.sv
// Emits N full periods of a 50% square wave with a programmable half-period, then pulses done.
module frequency_generator
    import freq_gen_pkg::*;
#(
    parameter int WIDTH = freq_gen_pkg::WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    frequency_generator_if.slave  bus
);

    fg_state_t        state_q, state_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] sent_q, sent_d;
    logic             wave_q, wave_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic [WIDTH-1:0] half_in;
    logic             timer_load;
    logic [WIDTH-1:0] timer_val;
    logic             timer_expire;

    assign start_ok = (state_q == IDLE) && bus.start && !bus.abort;
    assign half_in  = (bus.half_period < WIDTH'(HALF_MIN)) ? WIDTH'(HALF_MIN) : bus.half_period;

    half_period_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        num_d      = num_q;
        sent_d     = sent_q;
        wave_d     = wave_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = half_q - WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    half_d     = half_in;
                    num_d      = bus.num_cycles;
                    sent_d     = '0;
                    timer_load = 1'b1;
                    timer_val  = half_in - WIDTH'(1);
                    if (bus.num_cycles == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        wave_d  = 1'b0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        wave_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    wave_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (timer_expire) begin
                    timer_load = 1'b1;
                    if (wave_q) begin
                        wave_d = 1'b0;
                        sent_d = sent_q + WIDTH'(1);
                    end else if (sent_q == num_q) begin
                        // Low phase of the last period just ended; wave is already 0.
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        wave_d = 1'b1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            half_q  <= WIDTH'(HALF_MIN);
            num_q   <= '0;
            sent_q  <= '0;
            wave_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            wave_q  <= wave_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.wave        = wave_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycles_sent = sent_q;

endmodule
